// File: rtl/dc_ipu_div_unit_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional round-half-up quotient when DC_IPU_DIV_ROUND_EN is defined (adds a ROUND state).
module dc_ipu_div_unit_seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready_o is high only in IDLE and valid_o only in DONE, so a result is never overtaken.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
`ifdef DC_IPU_DIV_ROUND_EN
    ROUND = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  dvd_q;
  logic [WIDTH-1:0]  dsr_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dbz_q;

  // Shifted partial remainder; its top bit only matters for the trial comparison.
  logic [WIDTH:0]    shifted;
  logic              trial_ge;
  logic              last_iter;

  assign shifted   = {rem_q, dvd_q[WIDTH-1]};
  assign trial_ge  = (shifted >= {1'b0, dsr_q});
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
`ifdef DC_IPU_DIV_ROUND_EN
          state_d = ROUND;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef DC_IPU_DIV_ROUND_EN
      ROUND: state_d = DONE;
`endif
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= '0;
            if (divisor == '0) begin
              quo_q <= '1;
              rem_q <= dividend;
              dbz_q <= 1'b1;
            end else begin
              quo_q <= '0;
              rem_q <= '0;
              dbz_q <= 1'b0;
            end
          end
        end
        CALC: begin
          dvd_q <= dvd_q << 1;
          quo_q <= {quo_q[WIDTH-2:0], trial_ge};
          // A restored value is always below the divisor, so it fits in WIDTH bits.
          rem_q <= trial_ge ? WIDTH'(shifted - {1'b0, dsr_q}) : shifted[WIDTH-1:0];
          cnt_q <= cnt_q + CNT_W'(1);
        end
`ifdef DC_IPU_DIV_ROUND_EN
        ROUND: begin
          // Round half up; remainder stays the truncating one.
          if ({rem_q, 1'b0} >= {1'b0, dsr_q}) begin
            quo_q <= quo_q + WIDTH'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_dc_ipu_div_unit_seq_divider.sv
// Bench for dc_ipu_div_unit_seq_divider: vector table, hand-written corner sequences
// and randomized operations against an arithmetic model.
module tb_dc_ipu_div_unit_seq_divider;

  localparam int W = 16;
`ifdef DC_IPU_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i, ready_o, valid_o, ready_i, div_by_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  int checks = 0;
  int errors = 0;
  logic [2*W:0] exp_q[$];   // {quotient, remainder, div_by_zero}

  dc_ipu_div_unit_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .dividend    (dividend),
    .divisor     (divisor),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned q, r;
    if (b == 0) return {{W{1'b1}}, a, 1'b1};
    q = a / b;
    r = a % b;
    if (RND != 0 && 2 * r >= b) q = q + 1;
    return {q[W-1:0], r[W-1:0], 1'b0};
  endfunction

  // Edges after the acceptance edge until valid_o is seen.
  function automatic int exp_lat(input logic [W-1:0] b);
    return (b == 0) ? 0 : W + RND;
  endfunction

  // ---------------- driver ----------------
  // Entered and left at a falling edge. Pops the expected result from exp_q.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int bp,
                        input string tag);
    logic [2*W:0] e;
    int guard, lat;
    guard = 0;
    while (!ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready_before"}, 32'(ready_o), 1);
    dividend = a;
    divisor  = b;
    valid_i  = 1'b1;
    ready_i  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_i  = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(b)));
    chk({tag, "_quotient"}, 32'(quotient), 32'(e[2*W:W+1]));
    chk({tag, "_remainder"}, 32'(remainder), 32'(e[W:1]));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e[0]));
    chk({tag, "_ready_busy"}, 32'(ready_o), 0);
    // Backpressure with stray operand pulses that must be ignored.
    for (int i = 0; i < bp; i++) begin
      valid_i  = 1'($urandom_range(0, 1));
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      chk({tag, "_hold_q"}, 32'(quotient), 32'(e[2*W:W+1]));
      chk({tag, "_hold_r"}, 32'(remainder), 32'(e[W:1]));
      chk({tag, "_hold_valid"}, 32'(valid_o), 1);
      chk({tag, "_hold_ready"}, 32'(ready_o), 0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    chk({tag, "_valid_after"}, 32'(valid_o), 0);
    chk({tag, "_ready_after"}, 32'(ready_o), 1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           bp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int lat;
    logic [W-1:0] a, b;

    tbl[0]  = '{16'd100,   16'd7,     16'd14,                       16'd2,  1'b0, 0};
    tbl[1]  = '{16'hFFFF,  16'd1,     16'hFFFF,                     16'd0,  1'b0, 0};
    tbl[2]  = '{16'd3,     16'd10,    16'd0,                        16'd3,  1'b0, 1};
    tbl[3]  = '{16'd5,     16'd0,     16'hFFFF,                     16'd5,  1'b1, 0};
    tbl[4]  = '{16'd1000,  16'd33,    16'd30,                       16'd10, 1'b0, 5};
    tbl[5]  = '{16'd20,    16'd7,     (RND != 0) ? 16'd3 : 16'd2,   16'd6,  1'b0, 0};
    tbl[6]  = '{16'hFFFF,  16'd2,     (RND != 0) ? 16'h8000 : 16'h7FFF, 16'd1, 1'b0, 2};
    tbl[7]  = '{16'd0,     16'd5,     16'd0,                        16'd0,  1'b0, 0};
    tbl[8]  = '{16'd6,     16'd3,     16'd2,                        16'd0,  1'b0, 0};
    tbl[9]  = '{16'hFFFF,  16'hFFFF,  16'd1,                        16'd0,  1'b0, 0};
    tbl[10] = '{16'd1,     16'hFFFF,  16'd0,                        16'd1,  1'b0, 0};
    tbl[11] = '{16'd0,     16'd0,     16'hFFFF,                     16'd0,  1'b1, 3};
    tbl[12] = '{16'd7,     16'd2,     (RND != 0) ? 16'd4 : 16'd3,   16'd1,  1'b0, 0};

    // Reset state.
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);

    // Table.
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back({tbl[i].q, tbl[i].r, tbl[i].dbz});
      run_op(tbl[i].a, tbl[i].b, tbl[i].bp, $sformatf("vec%0d", i));
    end

    // Back-to-back with valid_i held high and ready_i high.
    dividend = 16'hFFFF; divisor = 16'd1; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 16'd3; divisor = 16'd10;
    lat = 0;
    while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
    chk("b2b_first_lat", 32'(lat), 32'(W + RND));
    chk("b2b_first_q", 32'(quotient), 32'hFFFF);
    chk("b2b_first_r", 32'(remainder), 0);
    @(negedge clk);
    chk("b2b_ready", 32'(ready_o), 1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
    chk("b2b_second_lat", 32'(lat), 32'(W + RND));
    chk("b2b_second_q", 32'(quotient), 0);
    chk("b2b_second_r", 32'(remainder), 3);
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    chk("b2b_ready_end", 32'(ready_o), 1);

    // Reset in the middle of an operation.
    dividend = 16'd100; divisor = 16'd7; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(ready_o), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(ready_o), 1);
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_q", 32'(quotient), 0);
    chk("mid_rst_r", 32'(remainder), 0);
    chk("mid_rst_dbz", 32'(div_by_zero), 0);
    exp_q.push_back(model(16'd100, 16'd7));
    run_op(16'd100, 16'd7, 0, "after_rst");

    // Random operations against the model.
    for (int i = 0; i < 120; i++) begin
      a = W'($urandom);
      if ($urandom_range(0, 9) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = W'($urandom_range(1, 20));
      else b = W'($urandom);
      exp_q.push_back(model(a, b));
      run_op(a, b, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
